// File: rtl/pin_entry_pkg.sv
// Shared types and default sizing for the keypad PIN entry front end.
package pin_entry_pkg;

   localparam int DIGIT_W            = 4;
   localparam int DIGITS_DEF         = 4;
   localparam int TRIG_CYCLES_DEF    = 3;
   localparam int TIMEOUT_CYCLES_DEF = 1000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2,
      SEND    = 2'd3
   } state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector: one history flop, pulse while level is high and history is low.
module key_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b0;
      else     prev <= level;
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/pin_entry_collector.sv
// Collects hex keypad digits into a code and strobes it to the combo lock.
// Build option: define PIN_ENTRY_BACKSPACE_EN to enable the backspace button.
module pin_entry_collector
   import pin_entry_pkg::*;
#(
   parameter int DIGITS         = DIGITS_DEF,
   parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  keyValid,
   input  logic [3:0]            keyCode,
   input  logic                  btnEnter,
   input  logic                  btnClear,
   input  logic                  btnBack,
   input  logic                  entryBlock,
   output logic [4*DIGITS-1:0]   pinCode,
   output logic                  trig,
   output logic [2:0]            digitCount,
   output logic                  shortEntry
);

   localparam int W   = DIGIT_W * DIGITS;
   localparam int TCW = $clog2(TIMEOUT_CYCLES);
   localparam int SCW = $clog2(TRIG_CYCLES + 1);

   logic key_ev, ent_ev, clr_ev, back_ev;

   key_edge_detect u_key (.clk(clk), .rst(rst), .level(keyValid), .pulse(key_ev));
   key_edge_detect u_ent (.clk(clk), .rst(rst), .level(btnEnter), .pulse(ent_ev));
   key_edge_detect u_clr (.clk(clk), .rst(rst), .level(btnClear), .pulse(clr_ev));

`ifdef PIN_ENTRY_BACKSPACE_EN
   key_edge_detect u_back (.clk(clk), .rst(rst), .level(btnBack), .pulse(back_ev));
`else
   logic unused_back;
   assign unused_back = btnBack;
   assign back_ev     = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [W-1:0]     sr_q, sr_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [TCW-1:0]   tcnt_q, tcnt_d;
   logic [SCW-1:0]   scnt_q, scnt_d;
   logic [W-1:0]     pin_d;
   logic             trig_d, short_d;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      scnt_d  = scnt_q;
      pin_d   = pinCode;
      trig_d  = trig;
      short_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            tcnt_d = '0;
            // Clear and back are no-ops here but still outrank a same-cycle digit.
            if (!entryBlock && !clr_ev) begin
               if (ent_ev) begin
                  short_d = 1'b1;
               end else if (!back_ev && key_ev) begin
                  sr_d    = W'(keyCode);
                  cnt_d   = 3'd1;
                  state_d = (DIGITS == 1) ? FULL : COLLECT;
               end
            end
         end
         COLLECT, FULL: begin
            if (entryBlock || clr_ev || tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
               sr_d    = '0;
               cnt_d   = '0;
               tcnt_d  = '0;
               state_d = IDLE;
            end else if (ent_ev) begin
               tcnt_d = '0;
               if (state_q == FULL) begin
                  pin_d   = sr_q;
                  trig_d  = 1'b1;
                  scnt_d  = '0;
                  state_d = SEND;
               end else begin
                  short_d = 1'b1;
                  sr_d    = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end else if (back_ev) begin
               sr_d    = sr_q >> DIGIT_W;
               cnt_d   = cnt_q - 3'd1;
               tcnt_d  = '0;
               state_d = (cnt_q == 3'd1) ? IDLE : COLLECT;
            end else if (key_ev && state_q == COLLECT) begin
               sr_d   = (sr_q << DIGIT_W) | W'(keyCode);
               cnt_d  = cnt_q + 3'd1;
               tcnt_d = '0;
               if (cnt_q + 3'd1 == 3'(DIGITS)) state_d = FULL;
            end else begin
               // Digits arriving while FULL are dropped and do not refresh the timeout.
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         SEND: begin
            if (scnt_q == SCW'(TRIG_CYCLES - 1)) begin
               trig_d  = 1'b0;
               sr_d    = '0;
               cnt_d   = '0;
               tcnt_d  = '0;
               state_d = IDLE;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         tcnt_q     <= '0;
         scnt_q     <= '0;
         pinCode    <= '0;
         trig       <= 1'b0;
         shortEntry <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         scnt_q     <= scnt_d;
         pinCode    <= pin_d;
         trig       <= trig_d;
         shortEntry <= short_d;
      end
   end

   assign digitCount = cnt_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed and randomized checks of pin_entry_collector against a digit-queue model.
module tb_pin_entry_collector;

   logic        clk = 1'b0;
   logic        rst, keyValid, btnEnter, btnClear, btnBack, entryBlock;
   logic [3:0]  keyCode;
   logic [15:0] pinCode;
   logic        trig, shortEntry;
   logic [2:0]  digitCount;

   int checks = 0;
   int errors = 0;

   int          ntrig, nshort;
   logic        ftrig;
   logic [15:0] tpin;

   logic [3:0]  q[$];
   logic [15:0] mpin;

   always #5 clk = ~clk;

   pin_entry_collector dut (
      .clk(clk), .rst(rst), .keyValid(keyValid), .keyCode(keyCode),
      .btnEnter(btnEnter), .btnClear(btnClear), .btnBack(btnBack),
      .entryBlock(entryBlock), .pinCode(pinCode), .trig(trig),
      .digitCount(digitCount), .shortEntry(shortEntry)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raise the requested levels for one cycle, then hold all low; tally trig/shortEntry.
   task automatic ev(input logic k, input logic [3:0] c, input logic e, input logic cl,
                     input logic b);
      keyValid = k; keyCode = c; btnEnter = e; btnClear = cl; btnBack = b;
      tick;
      ntrig = int'(trig); nshort = int'(shortEntry); ftrig = trig; tpin = pinCode;
      keyValid = 1'b0; btnEnter = 1'b0; btnClear = 1'b0; btnBack = 1'b0;
      repeat (6) begin
         tick;
         ntrig  += int'(trig);
         nshort += int'(shortEntry);
      end
   endtask

   task automatic digit(input logic [3:0] c);
      ev(1'b1, c, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic enter;
      ev(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int          r;
      logic        blk;
      logic [3:0]  c;
      int          etrig, eshort;

      rst = 1'b1; keyValid = 0; keyCode = 0; btnEnter = 0; btnClear = 0; btnBack = 0;
      entryBlock = 0;
      repeat (3) tick;
      rst = 1'b0;
      tick;
      chk("reset_pin", 32'(pinCode), 32'h0);
      chk("reset_trig", 32'(trig), 32'h0);
      chk("reset_count", 32'(digitCount), 32'h0);
      chk("reset_short", 32'(shortEntry), 32'h0);

      digit(4'hA); digit(4'hB); digit(4'hC); digit(4'hD);
      chk("abcd_count", 32'(digitCount), 32'd4);
      enter;
      chk("abcd_trig_first", 32'(ftrig), 32'h1);
      chk("abcd_pin_first", 32'(tpin), 32'hABCD);
      chk("abcd_trig_len", 32'(ntrig), 32'd3);
      chk("abcd_count_after", 32'(digitCount), 32'd0);

      digit(4'hC); digit(4'hA);
      enter;
      chk("short_pulses", 32'(nshort), 32'd1);
      chk("short_no_trig", 32'(ntrig), 32'd0);
      chk("short_pin_kept", 32'(pinCode), 32'hABCD);
      chk("short_count", 32'(digitCount), 32'd0);

      digit(4'hF); digit(4'hA); digit(4'hC); digit(4'hE); digit(4'h1);
      chk("ovf_count", 32'(digitCount), 32'd4);
      enter;
      chk("ovf_pin", 32'(pinCode), 32'hFACE);
      chk("ovf_trig_len", 32'(ntrig), 32'd3);

      digit(4'hD); digit(4'hA);
      repeat (992) tick;
      chk("timeout_not_yet", 32'(digitCount), 32'd2);
      repeat (4) tick;
      chk("timeout_cleared", 32'(digitCount), 32'd0);
      digit(4'hD); digit(4'hA); digit(4'hD); digit(4'hA);
      enter;
      chk("timeout_then_pin", 32'(pinCode), 32'hDADA);

      digit(4'hB); digit(4'hA); digit(4'hB); digit(4'hA);
      ev(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      chk("clr_wins_trig", 32'(ntrig), 32'd0);
      chk("clr_wins_pin", 32'(pinCode), 32'hDADA);
      chk("clr_wins_count", 32'(digitCount), 32'd0);

      digit(4'h3); digit(4'h4);
      entryBlock = 1'b1;
      tick;
      chk("block_abort", 32'(digitCount), 32'd0);
      digit(4'h5);
      enter;
      chk("block_digit_ignored", 32'(digitCount), 32'd0);
      chk("block_enter_ignored", 32'(nshort), 32'd0);
      entryBlock = 1'b0;
      tick;

`ifdef PIN_ENTRY_BACKSPACE_EN
      digit(4'hC); digit(4'hA); digit(4'h7);
      ev(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("back_count", 32'(digitCount), 32'd2);
      digit(4'hC); digit(4'hA);
      enter;
      chk("back_pin", 32'(pinCode), 32'hCACA);
      mpin = 16'hCACA;
`else
      digit(4'hC); digit(4'hA);
      ev(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("back_ignored", 32'(digitCount), 32'd2);
      ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      mpin = 16'hDADA;
`endif

      // Randomized phase: model keeps the held digits as a queue.
      q.delete();
      for (int i = 0; i < 80; i++) begin
         r      = int'($urandom_range(0, 15));
         blk    = ($urandom_range(0, 11) == 0);
         c      = 4'($urandom_range(0, 15));
         etrig  = 0;
         eshort = 0;
         entryBlock = blk;
         if (r < 10) begin
            digit(c);
            if (blk) q.delete();
            else if (q.size() < 4) q.push_back(c);
         end else if (r < 12) begin
            ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
            q.delete();
         end else begin
            enter;
            if (!blk) begin
               if (q.size() == 4) begin
                  mpin  = {q[0], q[1], q[2], q[3]};
                  etrig = 3;
               end else begin
                  eshort = 1;
               end
            end
            q.delete();
         end
         entryBlock = 1'b0;
         chk("rnd_count", 32'(digitCount), 32'(q.size()));
         chk("rnd_pin", 32'(pinCode), 32'(mpin));
         chk("rnd_trig", 32'(ntrig), 32'(etrig));
         chk("rnd_short", 32'(nshort), 32'(eshort));
      end

      ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      digit(4'h1); digit(4'h2); digit(4'h3); digit(4'h4);
      btnEnter = 1'b1;
      tick;
      btnEnter = 1'b0;
      tick;
      chk("rst_send_trig_before", 32'(trig), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("rst_send_trig", 32'(trig), 32'h0);
      chk("rst_send_pin", 32'(pinCode), 32'h0);
      tick;
      rst = 1'b0;
      tick;
      chk("rst_send_count", 32'(digitCount), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pin_entry_collector.md
Name: pin_entry_collector

Overview:
- Front end feeding the combo lock state machine. It assembles hex keypad digits into the 16-bit pinCode and drives the trig strobe that the lock consumes.
- Sits between the keypad scanner and comboLockStateMachine; pinCode and trig connect straight to the lock's inputs.
- Handles digit collection, overflow, clear, short-entry rejection, inactivity timeout, and blocking while the lock is busy or locked out.

Parameters:
- DIGITS, 4, number of hex digits per code; pinCode width = 4*DIGITS.
- TRIG_CYCLES, 3, cycles trig is held high per submission (≥1).
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT/FULL before the entry is discarded (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- keyValid  input  1  level from scanner; rising edge = new digit.
- keyCode  input  4  hex digit 0x0–0xF, sampled on keyValid rising edge.
- btnEnter  input  1  level; rising edge = submit.
- btnClear  input  1  level; rising edge = discard entry.
- btnBack  input  1  level; rising edge = delete last digit (see Optional Feature).
- entryBlock  input  1  1 = ignore all key events (lock busy or locked out).
- pinCode  output  4*DIGITS  last submitted code, stable outside submissions.
- trig  output  1  submit strobe to the lock.
- digitCount  output  3  digits currently held (0..DIGITS).
- shortEntry  output  1  one-cycle pulse when Enter is pressed with fewer than DIGITS digits.

Behaviour:
- Inputs are synchronous to clk. Each button gets one prev flop; event = level & ~prev. An event is acted on at the same rising edge it is first sampled.
- Reset values:
  - pinCode = 0, trig = 0, digitCount = 0, shortEntry = 0.
  - shift register = 0, timeout counter = 0, all prev flops = 0, state = IDLE.
- Event priority per cycle: entryBlock > clear > enter > back > digit. Only the highest-priority event is acted on; lower ones in the same cycle are dropped.
- FSM states: IDLE, COLLECT, FULL, SEND.
- IDLE:
  - Digit: shift register = {0…, keyCode}; digitCount = 1; go COLLECT (or FULL if DIGITS == 1).
  - Enter: pulse shortEntry; stay IDLE.
  - Clear and back: no effect.
- COLLECT:
  - Digit: shift register = {sr[4*DIGITS-5:0], keyCode}; digitCount++. Go FULL when the count reaches DIGITS.
  - Enter: shortEntry pulse for 1 cycle; sr = 0; count = 0; go IDLE; pinCode unchanged; no trig.
- FULL:
  - Digits are ignored (count saturates at DIGITS; sr unchanged).
  - Enter: pinCode <= sr; trig <= 1; go SEND.
- SEND:
  - trig high for exactly TRIG_CYCLES cycles, then trig = 0.
  - Then sr = 0, digitCount = 0, go IDLE.
  - All key events and entryBlock are ignored in SEND; a submission is never aborted.
- Clear in COLLECT or FULL: sr = 0, count = 0, go IDLE; pinCode unchanged.
- entryBlock = 1 in COLLECT or FULL: same as clear (abort to IDLE). In IDLE it suppresses all events.
- Timeout:
  - The counter resets on every accepted event and on state entry.
  - It increments each cycle in COLLECT/FULL.
  - When it reaches TIMEOUT_CYCLES-1, the block behaves as clear at the next edge.
- pinCode changes only on the FULL→SEND transition and on reset.
- Reset mid-SEND: trig drops asynchronously, pinCode = 0.
- Enter latency: trig is high in the first cycle after the edge that samples the Enter rising edge.

Optional Feature:
- Macro: PIN_ENTRY_BACKSPACE_EN.
- Defined: a back event in COLLECT/FULL does sr = sr >> 4 and digitCount-- (FULL→COLLECT). If the count becomes 0, go IDLE. The event resets the timeout counter. In IDLE it has no effect.
- Undefined: btnBack is ignored entirely (its port remains for a stable interface), and no prev flop is instantiated for it.

Decomposition:
- Package pin_entry_pkg:
  - state enum (IDLE/COLLECT/FULL/SEND, 2-bit);
  - DIGIT_W = 4;
  - default DIGITS, TRIG_CYCLES and TIMEOUT_CYCLES constants.
- One sub-module, key_edge_detect: 1-bit prev flop on async rst producing a rising-edge pulse. Instantiate it for keyValid, btnEnter, btnClear and (when the macro is set) btnBack.

Test Plan:
- Digits A,B,C,D then Enter → pinCode = 16'hABCD from the cycle after Enter; trig high exactly 3 cycles; digitCount returns to 0.
- After that, digits C,A then Enter → shortEntry pulses once, trig stays 0, pinCode remains 16'hABCD.
- Digits F,A,C,E,1 then Enter → the fifth digit is ignored, digitCount = 4, pinCode = 16'hFACE.
- Digits D,A, then no input for 1000 cycles → digitCount = 0, state IDLE. A following D,A,D,A + Enter → pinCode = 16'hDADA.
- btnClear and btnEnter rise in the same cycle while FULL with BABA → clear wins, no trig, pinCode unchanged. Also: entryBlock = 1 mid-entry → abort; digits ignored while held high.
- With PIN_ENTRY_BACKSPACE_EN set: C,A,X, Back, C,A + Enter → pinCode = 16'hCACA. Also: rst asserted during SEND → trig = 0 and pinCode = 0 immediately.
